// File: rtl/fht_result_reader.sv
// Streams a finished FHT frame out of four bank RAMs as one sample per cycle,
// re-ordering each address line into bank order through a small 8-word FIFO.
module fht_result_reader #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iFHT_RDY,
    input  logic               iSTART_RD,
    output logic [A_BIT-1:0]   oADDR_RD,
    input  logic [D_BIT-1:0]   iDATA_0,
    input  logic [D_BIT-1:0]   iDATA_1,
    input  logic [D_BIT-1:0]   iDATA_2,
    input  logic [D_BIT-1:0]   iDATA_3,
    output logic [D_BIT-1:0]   oDATA,
    output logic               oVALID,
    input  logic               iREADY,
    output logic [A_BIT+1:0]   oIDX,
    output logic               oLAST,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oABORT
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam logic [A_BIT-1:0] LAST_ADDR = {A_BIT{1'b1}};
    localparam logic [A_BIT+1:0] LAST_IDX  = {(A_BIT+2){1'b1}};

    state_t           state;
    logic [D_BIT-1:0] fifo_mem [8];
    logic [2:0]       wr_ptr;
    logic [2:0]       rd_ptr;
    logic [3:0]       count;
    logic             in_flight;
    logic [A_BIT-1:0] addr;
    logic [A_BIT+1:0] out_idx;
    logic             done_q;
    logic             abort_q;

    logic fifo_valid;
    logic pop;
    logic push;
    logic can_issue;
    logic last_out;

    // A line may only be issued when the FIFO is guaranteed room for it and
    // for any line already on its way back from the RAM.
    always_comb begin
        fifo_valid = (count != 4'd0);
        pop        = fifo_valid && iREADY;
        push       = in_flight;
        last_out   = (out_idx == LAST_IDX);
        can_issue  = (state == READ) &&
                     ((count + (in_flight ? 4'd4 : 4'd0)) <= 4'd4);
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state     <= IDLE;
            wr_ptr    <= 3'd0;
            rd_ptr    <= 3'd0;
            count     <= 4'd0;
            in_flight <= 1'b0;
            addr      <= '0;
            out_idx   <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART_RD && iFHT_RDY) begin
                        state     <= READ;
                        addr      <= '0;
                        wr_ptr    <= 3'd0;
                        rd_ptr    <= 3'd0;
                        count     <= 4'd0;
                        in_flight <= 1'b0;
                        out_idx   <= '0;
                    end
                end
                default: begin
                    if (!iFHT_RDY) begin
                        // The core withdrew its result: throw away everything buffered.
                        state     <= IDLE;
                        wr_ptr    <= 3'd0;
                        rd_ptr    <= 3'd0;
                        count     <= 4'd0;
                        in_flight <= 1'b0;
                        addr      <= '0;
                        out_idx   <= '0;
                        abort_q   <= 1'b1;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + 3'd4;
                        end
                        if (pop) begin
                            rd_ptr  <= rd_ptr + 3'd1;
                            out_idx <= out_idx + 1'b1;
                        end
                        count     <= count + (push ? 4'd4 : 4'd0) - (pop ? 4'd1 : 4'd0);
                        in_flight <= can_issue;
                        if (can_issue) begin
                            if (addr == LAST_ADDR) begin
                                state <= DRAIN;
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                        if ((state == DRAIN) && pop && last_out) begin
                            state  <= IDLE;
                            addr   <= '0;
                            done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Returned line lands one cycle after its issue edge, stored in bank order.
    always_ff @(posedge iCLK) begin
        if (in_flight) begin
            fifo_mem[wr_ptr]        <= iDATA_0;
            fifo_mem[wr_ptr + 3'd1] <= iDATA_1;
            fifo_mem[wr_ptr + 3'd2] <= iDATA_2;
            fifo_mem[wr_ptr + 3'd3] <= iDATA_3;
        end
    end

    assign oADDR_RD = addr;
    assign oVALID   = fifo_valid;
    assign oDATA    = fifo_valid ? fifo_mem[rd_ptr] : '0;
    assign oIDX     = out_idx;
    assign oLAST    = fifo_valid && last_out;
    assign oBUSY    = (state != IDLE);
    assign oDONE    = done_q;
    assign oABORT   = abort_q;

endmodule

// File: tb/tb_fht_result_reader.sv
// Bench for fht_result_reader with A_BIT=3: frame-level model of the sample
// stream checked every cycle, plus hand-computed spot values.
module tb_fht_result_reader;

    localparam int D_BIT = 16;
    localparam int A_BIT = 3;
    localparam int NSAMP = 32;

    logic              clk;
    logic              rst_n;
    logic              fht_rdy;
    logic              start_rd;
    logic              ready;
    logic [A_BIT-1:0]  addr_rd;
    logic [D_BIT-1:0]  d0, d1, d2, d3;
    logic [D_BIT-1:0]  data_out;
    logic              valid;
    logic [A_BIT+1:0]  idx;
    logic              last;
    logic              busy;
    logic              done;
    logic              abort_p;

    logic [D_BIT-1:0]  ram [4][8];

    int  checks = 0;
    int  passes = 0;
    bit  check_en = 0;

    bit  m_busy = 0;
    bit  m_valid = 0;
    bit  m_done = 0;
    bit  m_abort = 0;
    int  m_idx = 0;
    int  m_lat = 0;

    fht_result_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
        .iCLK      (clk),
        .iRESET    (rst_n),
        .iFHT_RDY  (fht_rdy),
        .iSTART_RD (start_rd),
        .oADDR_RD  (addr_rd),
        .iDATA_0   (d0),
        .iDATA_1   (d1),
        .iDATA_2   (d2),
        .iDATA_3   (d3),
        .oDATA     (data_out),
        .oVALID    (valid),
        .iREADY    (ready),
        .oIDX      (idx),
        .oLAST     (last),
        .oBUSY     (busy),
        .oDONE     (done),
        .oABORT    (abort_p)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Registered-output bank RAMs
    always @(posedge clk) begin
        d0 <= ram[0][addr_rd];
        d1 <= ram[1][addr_rd];
        d2 <= ram[2][addr_rd];
        d3 <= ram[3][addr_rd];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input bit s, input bit f, input bit r, input bit rs);
        start_rd = s;
        fht_rdy  = f;
        ready    = r;
        rst_n    = rs;
    endtask

    // Frame-level model: a started frame shows sample 0 two edges later, then
    // one sample per accepted transfer until sample 31 is taken.
    initial begin
        forever begin
            @(posedge clk);
            m_done  = 0;
            m_abort = 0;
            if (!rst_n) begin
                m_busy = 0;
                m_idx  = 0;
                m_lat  = 0;
            end else if (m_busy && !fht_rdy) begin
                m_busy  = 0;
                m_abort = 1;
                m_idx   = 0;
            end else if (m_busy) begin
                if (m_valid && ready) begin
                    if (m_idx == NSAMP - 1) begin
                        m_busy = 0;
                        m_done = 1;
                        m_idx  = 0;
                    end else begin
                        m_idx++;
                    end
                end
                m_lat++;
            end else if (start_rd && fht_rdy) begin
                m_busy = 1;
                m_lat  = 0;
                m_idx  = 0;
            end
            m_valid = m_busy && (m_lat >= 2);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("valid", 32'(valid), 32'(m_valid));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("abort", 32'(abort_p), 32'(m_abort));
            if (m_valid) begin
                checkOutput("data", 32'(data_out), 32'(ram[m_idx % 4][m_idx / 4]));
                checkOutput("idx", 32'(idx), 32'(m_idx));
                checkOutput("last", 32'(last), 32'(m_idx == NSAMP - 1));
            end else if (!m_busy) begin
                checkOutput("addr_idle", 32'(addr_rd), 32'd0);
            end
        end
    end

    // mode 0: ready high, 1: stalls + ignored restart at idx 10,
    // 2: core drops ready at idx 14, 3: reset at idx 20, 4: extreme-value frame
    task automatic runFrame(input int mode);
        bit finished;
        bit s, f, r, rs;
        bit [3:0] pat;
        pat = 4'b1001;
        finished = 0;
        @(negedge clk);
        applyStimulus(1, 1, 1, 1);
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (mode == 0 && c == 3)  checkOutput("lit_s0", 32'(data_out), 32'd0);
            if (mode == 0 && c == 7)  checkOutput("lit_s4", 32'(data_out), 32'd100);
            if (mode == 0 && c == 34) checkOutput("lit_s31", 32'(data_out), 32'd703);
            if (mode == 0 && c == 34) checkOutput("lit_last", 32'(last), 32'd1);
            if (mode == 0 && c == 35) checkOutput("lit_done", 32'(done), 32'd1);
            if (mode == 4 && c == 3)  checkOutput("lit_min", 32'(data_out), 32'h8000);
            if (mode == 4 && c == 4)  checkOutput("lit_max", 32'(data_out), 32'h7FFF);
            if (!m_busy) begin
                finished = 1;
                break;
            end
            s = 0; f = 1; r = 1; rs = 1;
            if (mode == 1) begin
                r = pat[c % 4] ^ ($urandom_range(0, 7) == 0);
                s = (m_idx == 10);
            end
            if (mode == 2 && m_idx >= 14) f = 0;
            if (mode == 3 && m_idx == 20) rs = 0;
            applyStimulus(s, f, r, rs);
        end
        if (!finished) checkOutput("frame_timeout", 32'd1, 32'd0);
        applyStimulus(0, 1, 1, 1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 8; a++)
                ram[k][a] = 16'(100 * a + k);
        applyStimulus(0, 1, 1, 0);
        @(posedge clk);
        check_en = 1;
        @(negedge clk);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_data", 32'(data_out), 32'd0);
        checkOutput("rst_idx", 32'(idx), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_addr", 32'(addr_rd), 32'd0);
        applyStimulus(0, 1, 1, 1);

        // Start request without a finished transform is ignored
        @(negedge clk);
        applyStimulus(1, 0, 1, 1);
        repeat (3) @(negedge clk);
        checkOutput("lit_nostart", 32'(busy), 32'd0);
        applyStimulus(0, 1, 1, 1);

        runFrame(0);
        repeat (2) @(negedge clk);
        runFrame(1);
        repeat (2) @(negedge clk);

        runFrame(2);
        checkOutput("lit_abort", 32'(abort_p), 32'd1);
        checkOutput("lit_abort_valid", 32'(valid), 32'd0);
        @(negedge clk);
        runFrame(0);
        repeat (2) @(negedge clk);

        runFrame(3);
        checkOutput("lit_rst_valid", 32'(valid), 32'd0);
        checkOutput("lit_rst_idx", 32'(idx), 32'd0);
        checkOutput("lit_rst_data", 32'(data_out), 32'd0);
        checkOutput("lit_rst_pulse", 32'({done, abort_p}), 32'd0);
        @(negedge clk);
        runFrame(0);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 8; a++)
                ram[k][a] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
        runFrame(4);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

endmodule
